// File: rtl/mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_arbiter                                                               |
// | Shares one cartridge memory port between CHR, PRG and host requesters.    |
// | Optional host aging: define MEM_ARB_AGING_EN.                             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int ADDR_BITS     = 23,
    parameter int DATA_BITS     = 8,
    parameter int HOST_MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chr_req,
    input  logic [ADDR_BITS-1:0] chr_addr,
    input  logic                 chr_we,
    input  logic [DATA_BITS-1:0] chr_wdata,
    output logic                 chr_ack,
    output logic [DATA_BITS-1:0] chr_rdata,
    input  logic                 prg_req,
    input  logic [ADDR_BITS-1:0] prg_addr,
    input  logic                 prg_we,
    input  logic [DATA_BITS-1:0] prg_wdata,
    output logic                 prg_ack,
    output logic [DATA_BITS-1:0] prg_rdata,
    input  logic                 host_req,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic                 host_we,
    input  logic [DATA_BITS-1:0] host_wdata,
    output logic                 host_ack,
    output logic [DATA_BITS-1:0] host_rdata,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy
);

    localparam int         c_NPORT     = 3;
    localparam logic [1:0] c_CHR       = 2'd0;
    localparam logic [1:0] c_PRG       = 2'd1;
    localparam logic [1:0] c_HOST      = 2'd2;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACCESS = 1'b1;

    logic [c_NPORT-1:0]   w_req;
    logic [ADDR_BITS-1:0] w_req_addr  [c_NPORT];
    logic [c_NPORT-1:0]   w_req_we;
    logic [DATA_BITS-1:0] w_req_wdata [c_NPORT];

    logic [c_NPORT-1:0]   r_pend;
    logic [ADDR_BITS-1:0] r_slot_addr  [c_NPORT];
    logic [c_NPORT-1:0]   r_slot_we;
    logic [DATA_BITS-1:0] r_slot_wdata [c_NPORT];

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic                 w_start;
    logic                 w_done;
    logic [1:0]           w_win;
    logic [1:0]           r_grant;
    logic [c_NPORT-1:0]   w_clr;
    logic                 w_force_host;

    logic [ADDR_BITS-1:0] r_mem_addr;
    logic                 r_mem_we;
    logic [DATA_BITS-1:0] r_mem_wdata;
    logic [c_NPORT-1:0]   r_ack;
    logic [DATA_BITS-1:0] r_rdata [c_NPORT];

    assign w_req          = {host_req, prg_req, chr_req};
    assign w_req_we       = {host_we, prg_we, chr_we};
    assign w_req_addr[0]  = chr_addr;
    assign w_req_addr[1]  = prg_addr;
    assign w_req_addr[2]  = host_addr;
    assign w_req_wdata[0] = chr_wdata;
    assign w_req_wdata[1] = prg_wdata;
    assign w_req_wdata[2] = host_wdata;

    // Completing port's slot is released in the same edge that produces its ack.
    assign w_clr = w_done ? (3'b001 << r_grant) : 3'b000;

`ifdef MEM_ARB_AGING_EN
    localparam int                 c_AGE_W   = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(HOST_MAX_WAIT);

    logic [c_AGE_W-1:0] r_age;

    assign w_force_host = r_pend[c_HOST] && (r_age >= c_AGE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= '0;
        end else if (w_start) begin
            if (w_win == c_HOST) begin
                r_age <= '0;
            end else if (r_pend[c_HOST] && (r_age != c_AGE_MAX)) begin
                r_age <= r_age + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^HOST_MAX_WAIT;
    assign w_force_host = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        if (w_force_host) begin
            w_win = c_HOST;
        end else if (r_pend[c_CHR]) begin
            w_win = c_CHR;
        end else if (r_pend[c_PRG]) begin
            w_win = c_PRG;
        end else begin
            w_win = c_HOST;
        end
        case (r_state)
            c_ST_IDLE: begin
                if (|r_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // A new request beats the release of the same slot in the completion cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_slot_we <= '0;
            for (int p = 0; p < c_NPORT; p++) begin
                r_slot_addr[p]  <= '0;
                r_slot_wdata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < c_NPORT; p++) begin
                if (w_req[p] && (!r_pend[p] || w_clr[p])) begin
                    r_pend[p]       <= 1'b1;
                    r_slot_addr[p]  <= w_req_addr[p];
                    r_slot_we[p]    <= w_req_we[p];
                    r_slot_wdata[p] <= w_req_wdata[p];
                end else if (w_clr[p]) begin
                    r_pend[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= c_CHR;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_ack       <= '0;
            for (int p = 0; p < c_NPORT; p++) begin
                r_rdata[p] <= '0;
            end
        end else begin
            r_ack <= w_clr;
            if (w_start) begin
                r_grant     <= w_win;
                r_mem_addr  <= r_slot_addr[w_win];
                r_mem_we    <= r_slot_we[w_win];
                r_mem_wdata <= r_slot_wdata[w_win];
            end
            if (w_done && !r_mem_we) begin
                r_rdata[r_grant] <= mem_rdata;
            end
        end
    end

    assign mem_req    = (r_state == c_ST_ACCESS);
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = (r_state != c_ST_IDLE) || (|r_pend);
    assign chr_ack    = r_ack[0];
    assign prg_ack    = r_ack[1];
    assign host_ack   = r_ack[2];
    assign chr_rdata  = r_rdata[0];
    assign prg_rdata  = r_rdata[1];
    assign host_rdata = r_rdata[2];

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_arbiter                                                            |
// | Directed bench for mem_arbiter with a transaction-level reference model.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int AW  = 23;
    localparam int DW  = 8;
    localparam int HMW = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req   = '0;
    logic [2:0]    we    = '0;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] wd   [3];
    logic          mem_ack   = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          chr_ack, prg_ack, host_ack;
    logic [DW-1:0] chr_rdata, prg_rdata, host_rdata;
    logic          mem_req, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    ackv;

    assign ackv = {host_ack, prg_ack, chr_ack};

    mem_arbiter #(
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW),
        .HOST_MAX_WAIT (HMW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chr_req    (req[0]),
        .chr_addr   (addr[0]),
        .chr_we     (we[0]),
        .chr_wdata  (wd[0]),
        .chr_ack    (chr_ack),
        .chr_rdata  (chr_rdata),
        .prg_req    (req[1]),
        .prg_addr   (addr[1]),
        .prg_we     (we[1]),
        .prg_wdata  (wd[1]),
        .prg_ack    (prg_ack),
        .prg_rdata  (prg_rdata),
        .host_req   (req[2]),
        .host_addr  (addr[2]),
        .host_we    (we[2]),
        .host_wdata (wd[2]),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a);
        logic [DW-1:0] lo;
        lo = a[DW-1:0];
        return (a == 23'h000123) ? 8'hA5 : (lo ^ 8'h3C);
    endfunction

    // ---------------- reference model ----------------
    logic [2:0]    m_pend;
    logic [2:0]    m_ack;
    logic [AW-1:0] m_saddr [3];
    logic [2:0]    m_swe;
    logic [DW-1:0] m_swd   [3];
    logic [DW-1:0] m_rd    [3];
    bit            m_active;
    int            m_win;
    int            m_age;
    logic [AW-1:0] m_taddr;
    bit            m_twe;
    logic [DW-1:0] m_twd;

    task automatic model_reset();
        m_pend   = '0;
        m_ack    = '0;
        m_swe    = '0;
        m_active = 1'b0;
        m_win    = 0;
        m_age    = 0;
        m_taddr  = '0;
        m_twe    = 1'b0;
        m_twd    = '0;
        for (int i = 0; i < 3; i++) begin
            m_saddr[i] = '0;
            m_swd[i]   = '0;
            m_rd[i]    = '0;
        end
    endtask

    function automatic int pick();
`ifdef MEM_ARB_AGING_EN
        if (m_pend[2] && m_age >= HMW) return 2;
`endif
        for (int i = 0; i < 3; i++) begin
            if (m_pend[i]) return i;
        end
        return 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_ack = '0;
                if (m_active) begin
                    if (mem_ack) begin
                        m_ack[m_win] = 1'b1;
                        if (!m_twe) m_rd[m_win] = mem_rdata;
                        m_pend[m_win] = 1'b0;
                        m_active = 1'b0;
                    end
                end else if (m_pend != 3'b000) begin
                    m_win = pick();
                    if (m_win == 2) m_age = 0;
                    else if (m_pend[2]) m_age++;
                    m_taddr  = m_saddr[m_win];
                    m_twe    = m_swe[m_win];
                    m_twd    = m_swd[m_win];
                    m_active = 1'b1;
                end
                for (int p = 0; p < 3; p++) begin
                    if (req[p] && !m_pend[p]) begin
                        m_pend[p]  = 1'b1;
                        m_saddr[p] = addr[p];
                        m_swe[p]   = we[p];
                        m_swd[p]   = wd[p];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("mem_req", 32'(mem_req), 32'(m_active));
            check("mem_cmd", {mem_we, mem_wdata, mem_addr}, {m_twe, m_twd, m_taddr});
            check("acks", 32'(ackv), 32'(m_ack));
            check("rdata", {8'h00, host_rdata, prg_rdata, chr_rdata}, {8'h00, m_rd[2], m_rd[1], m_rd[0]});
            check("busy", 32'(busy), 32'(m_active || (m_pend != 3'b000)));
        end
    end

    // ---------------- stimulus and memory responder ----------------
    int tcount = 0;
    int lat    = 2;
    int lat_cnt = 0;
    int ack_n     [3];
    int ack_first [3];
    int ack_last  [3];
    int t0;

    task automatic clear_rec();
        for (int p = 0; p < 3; p++) begin
            ack_n[p]     = 0;
            ack_first[p] = -1;
            ack_last[p]  = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        tcount++;
        req = '0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = AW'($urandom);
            wd[p]   = DW'($urandom);
            we[p]   = 1'($urandom);
        end
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
        if (mem_req) begin
            lat_cnt++;
            if (lat_cnt == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
                lat_cnt   = 0;
            end
        end else begin
            lat_cnt = 0;
        end
        for (int p = 0; p < 3; p++) begin
            if (ackv[p]) begin
                ack_n[p]++;
                if (ack_first[p] < 0) ack_first[p] = tcount;
                ack_last[p] = tcount;
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic issue(int p, logic [AW-1:0] a, logic w, logic [DW-1:0] d);
        req[p]  = 1'b1;
        addr[p] = a;
        we[p]   = w;
        wd[p]   = d;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        check("drain_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0;
            wd[p]   = '0;
        end
        clear_rec();
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_acks", 32'(ackv), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_cmd", {mem_we, mem_wdata, mem_addr}, 32'h0);
        check("rst_rdata", {8'h00, host_rdata, prg_rdata, chr_rdata}, 32'h0);
        rst_n = 1'b1;
        tick();

        // single PRG read
        clear_rec();
        issue(1, 23'h000123, 1'b0, 8'h00);
        t0 = tcount;
        run(2);
        check("t1_req_we", 32'({mem_req, mem_we}), 32'b10);
        check("t1_addr", 32'(mem_addr), 32'h123);
        run(10);
        check("t1_prg_ack_cycle", ack_first[1], t0 + 4);
        check("t1_prg_rdata", 32'(prg_rdata), 32'hA5);
        check("t1_chr_acks", ack_n[0], 0);
        check("t1_host_acks", ack_n[2], 0);
        drain();

        // three simultaneous reads
        clear_rec();
        issue(0, 23'h000040, 1'b0, 8'h00);
        issue(1, 23'h000041, 1'b0, 8'h00);
        issue(2, 23'h000042, 1'b0, 8'h00);
        t0 = tcount;
        run(14);
        check("t2_chr_ack", ack_first[0], t0 + 4);
        check("t2_prg_ack", ack_first[1], t0 + 7);
        check("t2_host_ack", ack_first[2], t0 + 10);
        check("t2_rdata", {8'h00, host_rdata, prg_rdata, chr_rdata}, 32'h007E7D7C);
        drain();

        // host read then host write with latency 3
        clear_rec();
        issue(2, 23'h000020, 1'b0, 8'h00);
        run(8);
        check("t3_host_rd", 32'(host_rdata), 32'h1C);
        lat = 3;
        clear_rec();
        issue(2, 23'h000010, 1'b1, 8'h5A);
        t0 = tcount;
        run(2);
        check("t3_req_we", 32'({mem_req, mem_we}), 32'b11);
        check("t3_wdata", 32'(mem_wdata), 32'h5A);
        check("t3_addr", 32'(mem_addr), 32'h10);
        run(8);
        check("t3_host_ack", ack_first[2], t0 + 5);
        check("t3_host_rdata_kept", 32'(host_rdata), 32'h1C);
        lat = 2;
        drain();

        // second PRG request while pending is dropped
        clear_rec();
        issue(1, 23'h000100, 1'b0, 8'h00);
        t0 = tcount;
        tick();
        issue(1, 23'h000200, 1'b0, 8'h00);
        tick();
        check("t4_addr", 32'(mem_addr), 32'h100);
        run(12);
        check("t4_prg_acks", ack_n[1], 1);
        drain();

        // PRG request in its own completion cycle
        clear_rec();
        issue(1, 23'h000300, 1'b0, 8'h00);
        t0 = tcount;
        run(3);
        issue(1, 23'h000301, 1'b0, 8'h00);
        run(10);
        check("t5_prg_acks", ack_n[1], 2);
        check("t5_first", ack_first[1], t0 + 4);
        check("t5_last", ack_last[1], t0 + 7);
        check("t5_rdata", 32'(prg_rdata), 32'h3D);
        drain();

        // CHR/PRG hammering with HOST pending
        clear_rec();
        issue(0, 23'h000400, 1'b0, 8'h00);
        issue(1, 23'h000500, 1'b0, 8'h00);
        issue(2, 23'h000600, 1'b0, 8'h00);
        t0 = tcount;
        for (int i = 0; i < 30; i++) begin
            tick();
            issue(0, 23'h000400 + AW'(i), 1'b0, 8'h00);
            issue(1, 23'h000500 + AW'(i), 1'b0, 8'h00);
        end
`ifdef MEM_ARB_AGING_EN
        check("t6_host_aged", ack_first[2], t0 + 13);
`else
        check("t6_host_starved", ack_n[2], 0);
`endif
        check("t6_chr_first", ack_first[0], t0 + 4);
        drain();

        // reset during a transaction, then a stray mem_ack
        clear_rec();
        issue(0, 23'h000700, 1'b0, 8'h00);
        run(2);
        check("t7_mem_req_pre", 32'(mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_mem_req_async", 32'(mem_req), 32'h0);
        check("t7_busy_async", 32'(busy), 32'h0);
        run(2);
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b1;
        run(5);
        check("t7_no_acks", ack_n[0] + ack_n[1] + ack_n[2], 0);
        check("t7_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one external cartridge memory port between three requesters: PPU CHR fetch, CPU PRG fetch and the host loader.
- Sits between the mapper bus address/strobe decode and the memory controller.
- Each requester issues single-cycle request pulses; the arbiter latches them, grants by priority, runs one memory transaction at a time and returns a one-cycle ack with read data.

## Interface

Parameters:
- ADDR_BITS, 23, memory address width (matches mapper bus address width)
- DATA_BITS, 8, data width
- HOST_MAX_WAIT, 15, cycles a pending host request may be passed over before forced grant (aging builds only)

Ports (`<p>` = chr, prg, host):
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- `<p>`_req  in  1  request pulse; qualifies addr/we/wdata this cycle
- `<p>`_addr  in  ADDR_BITS  request address
- `<p>`_we  in  1  1 = write, 0 = read
- `<p>`_wdata  in  DATA_BITS  write data
- `<p>`_ack  out  1  one-cycle completion pulse
- `<p>`_rdata  out  DATA_BITS  read data, valid with ack, held until next read ack on that port
- mem_req  out  1  memory request, held high until mem_ack
- mem_addr  out  ADDR_BITS  registered granted address
- mem_we  out  1  registered granted write flag
- mem_wdata  out  DATA_BITS  registered granted write data
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid same cycle
- mem_rdata  in  DATA_BITS  memory read data
- busy  out  1  high whenever state is not IDLE or any request is pending

## Operation

- Per-port pending slot: `<p>`_req sets pending and latches addr/we/wdata.
- A req arriving while that port's slot is already pending is dropped; the latched request is unchanged.
- FSM:
  - IDLE: if any slot is pending, pick the winner by CHR > PRG > HOST; load mem_addr/we/wdata from its slot; record grant; go to ACCESS.
  - ACCESS: mem_req = 1; on mem_ack go to IDLE, clear the winner's pending, pulse `<p>`_ack next cycle, latch mem_rdata into `<p>`_rdata for reads only.
- mem_ack in IDLE is ignored.
- In the completion cycle, the winner's clear and a new req on the same port: set wins, new request latched.
- Only the granted port is acked; other pending slots are untouched.
- Reset values:
  - all acks, mem_req, mem_we and busy = 0
  - mem_addr, mem_wdata and all rdata = 0
  - all pending = 0; FSM in IDLE; aging counter = 0
- Reset mid-transaction:
  - mem_req drops asynchronously.
  - The in-flight transaction is abandoned; no ack is issued.
  - A late mem_ack after reset release is ignored.

## Timing

- req in cycle t → pending at t+1 → arbitration in IDLE at t+1 → mem_req high at t+2.
- mem_ack in cycle c → `<p>`_ack and rdata valid in c+1; FSM in IDLE in c+1.
- mem_ack may arrive no earlier than the second cycle of mem_req.
- Minimum read latency: req at t, ack at t+4 (mem_ack at t+3).
- Back-to-back throughput: one transaction per (memory latency + 1) cycles, memory latency counted in mem_req-high cycles.
- A CHR request pending in the IDLE cycle always beats PRG/HOST pending in the same cycle, except when host aging forces a grant.

## Configuration

- MEM_ARB_AGING_EN defined:
  - A saturating counter increments each IDLE arbitration where host is pending but not granted; it does not count while host is not pending.
  - When the counter ≥ HOST_MAX_WAIT, host wins the next arbitration regardless of CHR/PRG.
  - The counter clears when host is granted.
- MEM_ARB_AGING_EN undefined: strict CHR > PRG > HOST priority; HOST_MAX_WAIT unused; host may starve.

## Test plan

- Single PRG read addr 0x0123, memory returns 0xA5 after 1 cycle → prg_ack at t+4, prg_rdata = 0xA5, mem_we = 0, chr/host ack never pulse.
- CHR, PRG and HOST req in the same cycle, memory latency 2 → ack order chr, prg, host, spaced 3 cycles apart.
- HOST write 0x5A to 0x000010 → mem_we = 1, mem_wdata = 0x5A, host_ack pulses; host_rdata keeps its previous value.
- Aging build, HOST_MAX_WAIT = 3, CHR and PRG re-requesting continuously with host pending → host granted at the 4th arbitration. Non-aging build → host never granted while CHR/PRG stay pending.
- Second prg_req while PRG is pending (different address) → only the first address appears on mem_addr, one prg_ack.
- PRG req in prg_ack's completion cycle → a second transaction runs.
- rst_n low while mem_req is high → mem_req = 0 immediately. After release, a stray mem_ack produces no ack and busy = 0.
